stepper_driver: RTL and testbench

STEPPER_DRIVER -- requirements
Module: stepper_driver

---
 rtl/stepper_pkg.sv | 21 ++
 rtl/stepper_driver_if.sv | 32 +++
 rtl/stepper_axis.sv | 101 ++++++++++
 rtl/stepper_driver.sv | 48 ++++
 tb/tb_stepper_driver.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_pkg.sv
// Shared types and widths for the two-axis stepper driver.
// Axis state encoding, speed-field width and position width live here.
package stepper_pkg;

  localparam int SPEED_W = 24;
  localparam int POS_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } axisState_t;

  // The step period never drops below minPeriod, so the low phase always lasts at least one clock.
  function automatic logic [SPEED_W-1:0] clampPeriod(input logic [SPEED_W-1:0] speed,
                                                     input int minPeriod);
    return (speed < SPEED_W'(minPeriod)) ? SPEED_W'(minPeriod) : speed;
  endfunction

endpackage

// File: rtl/stepper_driver_if.sv
// Command and motor-side signal bundle for the two-axis stepper driver.
// All signals are level-driven; there is no valid/ready handshake on this bus.
interface stepper_driver_if;
  import stepper_pkg::*;

  logic [31:0]      xSpeed;
  logic [31:0]      xDirection;
  logic [31:0]      ySpeed;
  logic [31:0]      yDirection;
  logic             zero_pos;
  logic             xStep;
  logic             yStep;
  logic             xDir;
  logic             yDir;
  logic [POS_W-1:0] xPos;
  logic [POS_W-1:0] yPos;
  logic             xBusy;
  logic             yBusy;
  axisState_t       xState;
  axisState_t       yState;

  modport master (
    output xSpeed, xDirection, ySpeed, yDirection, zero_pos,
    input  xStep, yStep, xDir, yDir, xPos, yPos, xBusy, yBusy, xState, yState
  );

  modport slave (
    input  xSpeed, xDirection, ySpeed, yDirection, zero_pos,
    output xStep, yStep, xDir, yDir, xPos, yPos, xBusy, yBusy, xState, yState
  );

endinterface

// File: rtl/stepper_axis.sv
// One stepper axis: IDLE/SETUP/HIGH/LOW sequencer, phase counter, latched period,
// direction register and signed position counter.
module stepper_axis
  import stepper_pkg::*;
#(
  parameter int STEP_HIGH  = 100,
  parameter int DIR_SETUP  = 50,
  parameter int MIN_PERIOD = 200
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic [31:0]      speed,
  input  logic [31:0]      direction,
  input  logic             zeroPos,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic [POS_W-1:0] pos,
  output axisState_t       state
);

  logic [SPEED_W-1:0] spd;
  logic               dirReq;
  logic               unusedBits;

  assign spd        = speed[SPEED_W-1:0];
  assign dirReq     = direction[0];
  assign unusedBits = ^{speed[31:SPEED_W], direction[31:1]};

  axisState_t         nextState;
  logic               nextDir;
  logic               phaseDone;
  logic               enterHigh;
  logic [SPEED_W-1:0] cnt;
  logic [SPEED_W-1:0] period;
  logic [SPEED_W-1:0] lowLen;

  always_comb begin
    nextState = state;
    nextDir   = dir;
    phaseDone = 1'b0;
    lowLen    = period - SPEED_W'(STEP_HIGH);
    case (state)
      IDLE:    phaseDone = 1'b1;
      SETUP:   phaseDone = (cnt == SPEED_W'(DIR_SETUP - 1));
      HIGH:    phaseDone = (cnt == SPEED_W'(STEP_HIGH - 1));
      LOW:     phaseDone = (cnt == lowLen - SPEED_W'(1));
      default: phaseDone = 1'b1;
    endcase
    if (phaseDone) begin
      case (state)
        HIGH:  nextState = LOW;
        SETUP: nextState = (spd != '0) ? HIGH : IDLE;
        // IDLE and end-of-LOW share one decision: stop, turn around, or step again.
        default: begin
          if (spd == '0) begin
            nextState = IDLE;
          end else if (dirReq != dir) begin
            nextState = SETUP;
            nextDir   = dirReq;
          end else begin
            nextState = HIGH;
          end
        end
      endcase
    end
    enterHigh = (nextState == HIGH) && (state != HIGH);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      period <= '0;
      dir    <= 1'b0;
      step   <= 1'b0;
      pos    <= '0;
    end else begin
      state <= nextState;
      dir   <= nextDir;
      step  <= (nextState == HIGH);
      if ((nextState != state) || (state == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + SPEED_W'(1);
      end
      if (enterHigh) begin
        period <= clampPeriod(spd, MIN_PERIOD);
      end
      // A clear coinciding with a step entry wins; that step is not counted.
      if (zeroPos) begin
        pos <= '0;
      end else if (enterHigh) begin
        pos <= nextDir ? pos + POS_W'(1) : pos - POS_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/stepper_driver.sv
// Two independent stepper axes sharing only clock, reset and the position-clear strobe.
module stepper_driver
  import stepper_pkg::*;
#(
  parameter int STEP_HIGH  = 100,
  parameter int DIR_SETUP  = 50,
  parameter int MIN_PERIOD = 200
) (
  input logic              clock,
  input logic              ctrl_reset,
  stepper_driver_if.slave  bus
);

  stepper_axis #(
    .STEP_HIGH (STEP_HIGH),
    .DIR_SETUP (DIR_SETUP),
    .MIN_PERIOD(MIN_PERIOD)
  ) xAxis (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .speed     (bus.xSpeed),
    .direction (bus.xDirection),
    .zeroPos   (bus.zero_pos),
    .step      (bus.xStep),
    .dir       (bus.xDir),
    .busy      (bus.xBusy),
    .pos       (bus.xPos),
    .state     (bus.xState)
  );

  stepper_axis #(
    .STEP_HIGH (STEP_HIGH),
    .DIR_SETUP (DIR_SETUP),
    .MIN_PERIOD(MIN_PERIOD)
  ) yAxis (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .speed     (bus.ySpeed),
    .direction (bus.yDirection),
    .zeroPos   (bus.zero_pos),
    .step      (bus.yStep),
    .dir       (bus.yDir),
    .busy      (bus.yBusy),
    .pos       (bus.yPos),
    .state     (bus.yState)
  );

endmodule

// File: tb/tb_stepper_driver.sv
// Bench for stepper_driver: expected step-rise cycles and positions are queued when a
// speed/direction command is driven and checked as each rising step edge appears.
module tb_stepper_driver;
  import stepper_pkg::*;

  localparam int STEP_HIGH  = 2;
  localparam int DIR_SETUP  = 3;
  localparam int MIN_PERIOD = 5;

  logic clock = 1'b0;
  logic ctrl_reset;
  logic rstQ = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  stepper_driver_if bus();

  stepper_driver #(
    .STEP_HIGH (STEP_HIGH),
    .DIR_SETUP (DIR_SETUP),
    .MIN_PERIOD(MIN_PERIOD)
  ) dut (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .bus       (bus)
  );

  // clock / reset bookkeeping
  always #5 clock = ~clock;
  always @(posedge clock) begin
    cyc  <= cyc + 1;
    rstQ <= ctrl_reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard queues: rise cycle and position seen on that rise
  logic [31:0] xRise_q[$];
  logic [31:0] xPos_q[$];
  logic [31:0] yRise_q[$];
  logic [31:0] yPos_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic pushX(input int riseCyc, input logic [31:0] posExp);
    xRise_q.push_back(32'(riseCyc));
    xPos_q.push_back(posExp);
  endtask

  task automatic pushY(input int riseCyc, input logic [31:0] posExp);
    yRise_q.push_back(32'(riseCyc));
    yPos_q.push_back(posExp);
  endtask

  // x monitor
  logic xPrev = 1'b0;
  int   xWidth = 0;
  always @(negedge clock) begin
    if (rstQ) begin
      xPrev  = 1'b0;
      xWidth = 0;
    end else begin
      if (bus.xStep && !xPrev) begin
        chk("x_rise_expected", 32'(xRise_q.size() > 0), 32'd1);
        if (xRise_q.size() > 0) begin
          chk("x_rise_cycle", 32'(cyc), xRise_q.pop_front());
          chk("x_pos_at_rise", bus.xPos, xPos_q.pop_front());
        end
      end
      if (!bus.xStep && xPrev) chk("x_high_width", 32'(xWidth), 32'(STEP_HIGH));
      xWidth = bus.xStep ? xWidth + 1 : 0;
      xPrev  = bus.xStep;
    end
  end

  // y monitor
  logic yPrev = 1'b0;
  int   yWidth = 0;
  always @(negedge clock) begin
    if (rstQ) begin
      yPrev  = 1'b0;
      yWidth = 0;
    end else begin
      if (bus.yStep && !yPrev) begin
        chk("y_rise_expected", 32'(yRise_q.size() > 0), 32'd1);
        if (yRise_q.size() > 0) begin
          chk("y_rise_cycle", 32'(cyc), yRise_q.pop_front());
          chk("y_pos_at_rise", bus.yPos, yPos_q.pop_front());
        end
      end
      if (!bus.yStep && yPrev) chk("y_high_width", 32'(yWidth), 32'(STEP_HIGH));
      yWidth = bus.yStep ? yWidth + 1 : 0;
      yPrev  = bus.yStep;
    end
  end

  int c0, c1, c2, c3, c4;
  logic [31:0] xModel;

  initial begin
    ctrl_reset     = 1'b1;
    bus.xSpeed     = '0;
    bus.xDirection = '0;
    bus.ySpeed     = '0;
    bus.yDirection = '0;
    bus.zero_pos   = 1'b0;
    xModel         = '0;
    repeat (3) @(negedge clock);

    chk("rst_xStep", 32'(bus.xStep), 32'd0);
    chk("rst_yStep", 32'(bus.yStep), 32'd0);
    chk("rst_xDir", 32'(bus.xDir), 32'd0);
    chk("rst_yDir", 32'(bus.yDir), 32'd0);
    chk("rst_xPos", bus.xPos, 32'd0);
    chk("rst_yPos", bus.yPos, 32'd0);
    chk("rst_busy", {30'd0, bus.xBusy, bus.yBusy}, 32'd0);
    chk("rst_xState", 32'(bus.xState), 32'(IDLE));
    ctrl_reset = 1'b0;
    @(negedge clock);

    // period 10, negative direction, stop during the third pulse
    c0 = cyc;
    bus.xSpeed     = 32'd10;
    bus.xDirection = 32'd0;
    for (int k = 0; k < 3; k++) begin
      xModel = xModel - 32'd1;
      pushX(c0 + 1 + 10 * k, xModel);
    end
    waitCyc(c0 + 21);
    bus.xSpeed = 32'd0;
    waitCyc(c0 + 30);
    chk("t1_busy_in_low", 32'(bus.xBusy), 32'd1);
    waitCyc(c0 + 31);
    chk("t1_busy_idle", 32'(bus.xBusy), 32'd0);
    chk("t1_xPos", bus.xPos, 32'hFFFF_FFFD);
    chk("t1_yStep", 32'(bus.yStep), 32'd0);
    chk("t1_yPos", bus.yPos, 32'd0);
    waitCyc(c0 + 40);
    chk("t1_still_idle", 32'(bus.xState), 32'(IDLE));

    // speed below minimum is clamped
    c1 = cyc;
    bus.xSpeed = 32'd3 | ($urandom_range(0, 255) << 24);
    for (int k = 0; k < 3; k++) begin
      xModel = xModel - 32'd1;
      pushX(c1 + 1 + MIN_PERIOD * k, xModel);
    end
    waitCyc(c1 + 11);
    bus.xSpeed = 32'd0;
    waitCyc(c1 + 16);
    chk("t2_busy_idle", 32'(bus.xBusy), 32'd0);
    chk("t2_xPos", bus.xPos, 32'hFFFF_FFFA);

    // direction reversal requested mid-LOW
    c2 = cyc;
    bus.xSpeed = 32'd6;
    xModel = xModel - 32'd1;
    pushX(c2 + 1, xModel);
    waitCyc(c2 + 4);
    bus.xDirection = 32'd1 | ($urandom_range(0, 7) << 1);
    xModel = xModel + 32'd1;
    pushX(c2 + 1 + 6 + DIR_SETUP, xModel);
    xModel = xModel + 32'd1;
    pushX(c2 + 1 + 6 + DIR_SETUP + 6, xModel);
    waitCyc(c2 + 6);
    chk("t3_dir_held_low", 32'(bus.xDir), 32'd0);
    waitCyc(c2 + 7);
    chk("t3_dir_flipped", 32'(bus.xDir), 32'd1);
    chk("t3_state_setup", 32'(bus.xState), 32'(SETUP));
    waitCyc(c2 + 16);
    bus.xSpeed = 32'd0;
    waitCyc(c2 + 22);
    chk("t3_busy_idle", 32'(bus.xBusy), 32'd0);
    chk("t3_xPos", bus.xPos, 32'hFFFF_FFFB);

    // clear, count up to 7, then clear on a step entry
    bus.zero_pos = 1'b1;
    waitCyc(cyc + 1);
    bus.zero_pos = 1'b0;
    chk("t4_zero_alone", bus.xPos, 32'd0);
    c3 = cyc;
    bus.xSpeed = 32'd5;
    for (int k = 0; k < 7; k++) pushX(c3 + 1 + 5 * k, 32'(k + 1));
    pushX(c3 + 36, 32'd0);
    waitCyc(c3 + 35);
    chk("t4_pos_seven", bus.xPos, 32'd7);
    bus.zero_pos = 1'b1;
    waitCyc(c3 + 36);
    bus.zero_pos = 1'b0;
    bus.xSpeed   = 32'd0;
    chk("t4_zero_wins", bus.xPos, 32'd0);
    chk("t4_step_high", 32'(bus.xStep), 32'd1);
    waitCyc(c3 + 41);
    chk("t4_busy_idle", 32'(bus.xBusy), 32'd0);

    // y axis: reversal from reset direction, then reset mid-pulse
    c4 = cyc;
    bus.ySpeed     = 32'd5;
    bus.yDirection = 32'd1;
    for (int k = 0; k < 5; k++) pushY(c4 + 1 + DIR_SETUP + 5 * k, 32'(k + 1));
    waitCyc(c4 + 24);
    chk("t5_yStep_high", 32'(bus.yStep), 32'd1);
    chk("t5_yPos_five", bus.yPos, 32'd5);
    chk("t5_yDir_one", 32'(bus.yDir), 32'd1);
    ctrl_reset = 1'b1;
    waitCyc(c4 + 25);
    chk("t5_rst_yStep", 32'(bus.yStep), 32'd0);
    chk("t5_rst_yDir", 32'(bus.yDir), 32'd0);
    chk("t5_rst_yPos", bus.yPos, 32'd0);
    chk("t5_rst_yBusy", 32'(bus.yBusy), 32'd0);
    bus.ySpeed     = 32'd0;
    bus.yDirection = 32'd0;
    ctrl_reset     = 1'b0;
    waitCyc(cyc + 10);
    chk("y_stays_idle", 32'(bus.yBusy), 32'd0);

    chk("x_queue_drained", 32'(xRise_q.size()), 32'd0);
    chk("y_queue_drained", 32'(yRise_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
